lfsr_noise_gen: RTL and testbench
=================================

Name: lfsr_noise_gen

Overview:
Parametrised Fibonacci LFSR noise source. It is the successor to the fixed 3-bit noise register, generalised in width, tap polynomial and seed. It adds:
- run-time seed loading with zero-seed protection
- step enable
- automatic period measurement
It feeds test-pattern and noise consumers with a 1-bit noise stream plus the full register word.

Parameters:
WIDTH, 16, register width in bits; legal range 2..32.
TAPS, 16'hB400, feedback tap mask; bit i set means state[i] is XORed into the feedback. Bit WIDTH-1 must be 1.
SEED, 16'h0001, reset and fallback state; must be non-zero.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high reset.
enable  in  1  advance the LFSR by one step this cycle.
load  in  1  load seed_in this cycle; has priority over enable.
seed_in  in  WIDTH  seed value used with load.
state_out  out  WIDTH  current LFSR register contents.
noise_bit  out  1  state_out[WIDTH-1].
valid  out  1  one-cycle pulse in the cycle after a step.
seed_err  out  1  one-cycle pulse in the cycle after a load with seed_in == 0.
period_pulse  out  1  one-cycle pulse when the state returns to the reference state.
period_len  out  WIDTH  length of the last completed period, in steps.

Behaviour:
Reset (reset=1 at a clock edge):
- state = SEED, ref = SEED, step_cnt = 0.
- valid = 0, seed_err = 0, period_pulse = 0, period_len = 0.
- Reset overrides load and enable.

Step (enable=1, load=0):
- state[WIDTH-1:1] <= state[WIDTH-2:0].
- state[0] <= XOR-reduce(state & TAPS).
- valid = 1 in the next cycle.

Hold (enable=0, load=0):
- state, step_cnt and ref are unchanged; all pulse outputs = 0.

Load (load=1, regardless of enable):
- seed_in != 0: state <= seed_in, ref <= seed_in.
- seed_in == 0: state <= SEED, ref <= SEED, seed_err pulses the next cycle.
- In both cases step_cnt <= 0, no step is taken, valid = 0.
- period_len is retained.

Period tracking, on each step:
- If next_state == ref: period_pulse = 1 next cycle, period_len <= step_cnt + 1, step_cnt <= 0.
- Otherwise step_cnt <= step_cnt + 1.
- step_cnt is WIDTH bits wide. It cannot overflow because the maximal period is 2^WIDTH-1.
- For non-maximal TAPS, the reported period is the cycle length containing ref.
- If ref is not on a cycle, no pulse occurs and step_cnt wraps modulo 2^WIDTH silently.

Output timing:
- All outputs are registered.
- state_out and noise_bit reflect the new state in the cycle after the step, coincident with valid.
- period_pulse coincides with the valid of the step that closed the period.

Zero state:
- Reachable only via load, which is blocked, so state is never 0.

Elaboration checks:
- Fatal if WIDTH<2, WIDTH>32, TAPS[WIDTH-1]==0, or SEED==0.

Reset mid-operation:
- Discards the partial count and ref; the period restarts from SEED.

Test Plan:
1. WIDTH=3, TAPS=3'b110, SEED=3'b001, reset then enable held 8 cycles -> state_out sequence 010,101,011,111,110,100,001,010. valid high every cycle. period_pulse on the 001 cycle with period_len=7.
2. Defaults, reset, one enable -> state_out=16'h0002, noise_bit=0, valid pulse. With enable held 65535 cycles -> period_pulse once, period_len=16'hFFFF, state_out=16'h0001.
3. Defaults, load=1 with seed_in=0 -> state_out=16'h0001, seed_err pulse, valid=0. Then load seed_in=16'hACE1 with enable=1 simultaneously -> state_out=16'hACE1, no step, valid=0.
4. WIDTH=3 config, enable toggled 1,0,1,0 -> state advances only on enabled cycles (001->010->010->101). valid pulses only after enabled cycles.
5. WIDTH=3 config, 3 steps, then reset asserted together with enable and load -> state_out=001, period_len=0, all pulses 0. Then 7 steps -> period_pulse with period_len=7.
6. WIDTH=4, TAPS=4'b1111 (non-maximal), SEED=4'b0001, enable held -> period_pulse with period_len=5, repeating every 5 steps.

Source files
------------

// File: rtl/lfsr_noise_gen.sv
// Parametrised Fibonacci LFSR noise source with seed load,
// zero-seed protection, step enable and period measurement.
//
// Ports:
//   clock        rising-edge clock
//   reset        synchronous active-high reset
//   enable       advance the LFSR one step
//   load         load seed_in (wins over enable)
//   seed_in      seed used with load; zero falls back to SEED
//   state_out    current register word
//   noise_bit    state_out[WIDTH-1]
//   valid        pulse in the cycle after a step
//   seed_err     pulse in the cycle after a zero-seed load
//   period_pulse pulse when the state returns to the reference
//   period_len   length of the last completed period, in steps
module lfsr_noise_gen #(
  parameter int unsigned          WIDTH = 16,
  parameter logic [WIDTH-1:0]     TAPS  = 16'hB400,
  parameter logic [WIDTH-1:0]     SEED  = 16'h0001
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] state_out,
  output logic             noise_bit,
  output logic             valid,
  output logic             seed_err,
  output logic             period_pulse,
  output logic [WIDTH-1:0] period_len
);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $fatal(1, "lfsr_noise_gen: WIDTH out of range");
  end
  if (TAPS[WIDTH-1] == 1'b0) begin : g_bad_taps
    $fatal(1, "lfsr_noise_gen: TAPS msb must be set");
  end
  if (SEED == '0) begin : g_bad_seed
    $fatal(1, "lfsr_noise_gen: SEED must be non-zero");
  end

  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] ref_state;
  logic [WIDTH-1:0] step_cnt;
  logic [WIDTH-1:0] nxt;
  logic             fb;
  logic             seed_zero;

  always_comb begin
    fb        = ^(state & TAPS);
    nxt       = {state[WIDTH-2:0], fb};
    seed_zero = (seed_in == '0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= SEED;
      ref_state    <= SEED;
      step_cnt     <= '0;
      valid        <= 1'b0;
      seed_err     <= 1'b0;
      period_pulse <= 1'b0;
      period_len   <= '0;
    end else begin
      valid        <= 1'b0;
      seed_err     <= 1'b0;
      period_pulse <= 1'b0;
      unique case (1'b1)
        load: begin
          // a zero seed would lock the register, so fall back
          state     <= seed_zero ? SEED : seed_in;
          ref_state <= seed_zero ? SEED : seed_in;
          seed_err  <= seed_zero;
          step_cnt  <= '0;
        end
        (enable & ~load): begin
          state <= nxt;
          valid <= 1'b1;
          if (nxt == ref_state) begin
            period_pulse <= 1'b1;
            period_len   <= step_cnt + 1'b1;
            step_cnt     <= '0;
          end else begin
            step_cnt <= step_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign state_out = state;
  assign noise_bit = state[WIDTH-1];

endmodule

// File: tb/tb_lfsr_noise_gen.sv
// Directed bench for lfsr_noise_gen: 16-bit default,
// 3-bit maximal and 4-bit non-maximal configurations.
module tb_lfsr_noise_gen;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // 16-bit default instance
  logic        a_reset, a_enable, a_load;
  logic [15:0] a_seed, a_state, a_len;
  logic        a_noise, a_valid, a_err, a_pulse;

  lfsr_noise_gen u_a (
    .clock(clock), .reset(a_reset), .enable(a_enable),
    .load(a_load), .seed_in(a_seed), .state_out(a_state),
    .noise_bit(a_noise), .valid(a_valid), .seed_err(a_err),
    .period_pulse(a_pulse), .period_len(a_len)
  );

  // 3-bit maximal instance
  logic       b_reset, b_enable, b_load;
  logic [2:0] b_seed, b_state, b_len;
  logic       b_noise, b_valid, b_err, b_pulse;

  lfsr_noise_gen #(.WIDTH(3), .TAPS(3'b110), .SEED(3'b001)) u_b (
    .clock(clock), .reset(b_reset), .enable(b_enable),
    .load(b_load), .seed_in(b_seed), .state_out(b_state),
    .noise_bit(b_noise), .valid(b_valid), .seed_err(b_err),
    .period_pulse(b_pulse), .period_len(b_len)
  );

  // 4-bit non-maximal instance
  logic       c_reset, c_enable, c_load;
  logic [3:0] c_seed, c_state, c_len;
  logic       c_noise, c_valid, c_err, c_pulse;

  lfsr_noise_gen #(.WIDTH(4), .TAPS(4'b1111), .SEED(4'b0001)) u_c (
    .clock(clock), .reset(c_reset), .enable(c_enable),
    .load(c_load), .seed_in(c_seed), .state_out(c_state),
    .noise_bit(c_noise), .valid(c_valid), .seed_err(c_err),
    .period_pulse(c_pulse), .period_len(c_len)
  );

  typedef struct {
    logic       rst, en, ld;
    logic [2:0] seed, st;
    logic       v, e, p;
    logic [2:0] len;
  } vec_t;

  vec_t tv[64];
  int   nv = 0;

  task automatic add(input logic rst, en, ld, input logic [2:0] seed,
                     input logic [2:0] st, input logic v, e, p,
                     input logic [2:0] len);
    tv[nv] = '{rst, en, ld, seed, st, v, e, p, len};
    nv++;
  endtask

  initial begin
    int pcount;
    logic [3:0] cexp [5];
    cexp = '{4'h3, 4'h6, 4'hC, 4'h8, 4'h1};

    a_reset = 1; a_enable = 0; a_load = 0; a_seed = '0;
    b_reset = 1; b_enable = 0; b_load = 0; b_seed = '0;
    c_reset = 1; c_enable = 0; c_load = 0; c_seed = '0;

    // rst en ld seed  state v e p len
    add(1, 0, 0, 3'd0, 3'b001, 0, 0, 0, 3'd0);
    add(0, 1, 0, 3'd0, 3'b010, 1, 0, 0, 3'd0);
    add(0, 1, 0, 3'd0, 3'b101, 1, 0, 0, 3'd0);
    add(0, 1, 0, 3'd0, 3'b011, 1, 0, 0, 3'd0);
    add(0, 1, 0, 3'd0, 3'b111, 1, 0, 0, 3'd0);
    add(0, 1, 0, 3'd0, 3'b110, 1, 0, 0, 3'd0);
    add(0, 1, 0, 3'd0, 3'b100, 1, 0, 0, 3'd0);
    add(0, 1, 0, 3'd0, 3'b001, 1, 0, 1, 3'd7);
    add(0, 1, 0, 3'd0, 3'b010, 1, 0, 0, 3'd7);
    // enable toggling
    add(1, 0, 0, 3'd0, 3'b001, 0, 0, 0, 3'd0);
    add(0, 1, 0, 3'd0, 3'b010, 1, 0, 0, 3'd0);
    add(0, 0, 0, 3'd0, 3'b010, 0, 0, 0, 3'd0);
    add(0, 1, 0, 3'd0, 3'b101, 1, 0, 0, 3'd0);
    add(0, 0, 0, 3'd0, 3'b101, 0, 0, 0, 3'd0);
    // reset mid-count, with enable and load asserted
    add(1, 0, 0, 3'd0, 3'b001, 0, 0, 0, 3'd0);
    add(0, 1, 0, 3'd0, 3'b010, 1, 0, 0, 3'd0);
    add(0, 1, 0, 3'd0, 3'b101, 1, 0, 0, 3'd0);
    add(0, 1, 0, 3'd0, 3'b011, 1, 0, 0, 3'd0);
    add(1, 1, 1, 3'd5, 3'b001, 0, 0, 0, 3'd0);
    add(0, 1, 0, 3'd0, 3'b010, 1, 0, 0, 3'd0);
    add(0, 1, 0, 3'd0, 3'b101, 1, 0, 0, 3'd0);
    add(0, 1, 0, 3'd0, 3'b011, 1, 0, 0, 3'd0);
    add(0, 1, 0, 3'd0, 3'b111, 1, 0, 0, 3'd0);
    add(0, 1, 0, 3'd0, 3'b110, 1, 0, 0, 3'd0);
    add(0, 1, 0, 3'd0, 3'b100, 1, 0, 0, 3'd0);
    add(0, 1, 0, 3'd0, 3'b001, 1, 0, 1, 3'd7);
    // zero-seed load, hold, then load beats enable
    add(0, 0, 1, 3'd0, 3'b001, 0, 1, 0, 3'd7);
    add(0, 0, 0, 3'd0, 3'b001, 0, 0, 0, 3'd7);
    add(0, 1, 1, 3'd3, 3'b011, 0, 0, 0, 3'd7);
    // period now measured against the loaded reference 011
    add(0, 1, 0, 3'd0, 3'b111, 1, 0, 0, 3'd7);
    add(0, 1, 0, 3'd0, 3'b110, 1, 0, 0, 3'd7);
    add(0, 1, 0, 3'd0, 3'b100, 1, 0, 0, 3'd7);
    add(0, 1, 0, 3'd0, 3'b001, 1, 0, 0, 3'd7);
    add(0, 1, 0, 3'd0, 3'b010, 1, 0, 0, 3'd7);
    add(0, 1, 0, 3'd0, 3'b101, 1, 0, 0, 3'd7);
    add(0, 1, 0, 3'd0, 3'b011, 1, 0, 1, 3'd7);

    for (int i = 0; i < nv; i++) begin
      b_reset = tv[i].rst; b_enable = tv[i].en;
      b_load = tv[i].ld; b_seed = tv[i].seed;
      @(posedge clock); #1;
      chk($sformatf("w3[%0d].state", i), b_state, tv[i].st);
      chk($sformatf("w3[%0d].noise", i), b_noise, tv[i].st[2]);
      chk($sformatf("w3[%0d].valid", i), b_valid, tv[i].v);
      chk($sformatf("w3[%0d].seed_err", i), b_err, tv[i].e);
      chk($sformatf("w3[%0d].pulse", i), b_pulse, tv[i].p);
      chk($sformatf("w3[%0d].len", i), b_len, tv[i].len);
    end
    b_enable = 0; b_load = 0;

    // 16-bit default: reset, first step, full period
    @(posedge clock); #1;
    chk("w16.rst.state", a_state, 16'h0001);
    chk("w16.rst.len", a_len, 16'h0000);
    chk("w16.rst.valid", a_valid, 1'b0);
    chk("w16.rst.pulse", a_pulse, 1'b0);
    a_reset = 0; a_enable = 1;
    @(posedge clock); #1;
    chk("w16.step1.state", a_state, 16'h0002);
    chk("w16.step1.noise", a_noise, 1'b0);
    chk("w16.step1.valid", a_valid, 1'b1);
    pcount = 0;
    for (int i = 0; i < 65534; i++) begin
      @(posedge clock); #1;
      if (a_pulse) pcount++;
    end
    chk("w16.period.count", pcount, 1);
    chk("w16.period.pulse", a_pulse, 1'b1);
    chk("w16.period.len", a_len, 16'hFFFF);
    chk("w16.period.state", a_state, 16'h0001);
    a_enable = 0;

    a_load = 1; a_seed = 16'h0000;
    @(posedge clock); #1;
    chk("w16.zload.state", a_state, 16'h0001);
    chk("w16.zload.err", a_err, 1'b1);
    chk("w16.zload.valid", a_valid, 1'b0);
    chk("w16.zload.len", a_len, 16'hFFFF);
    a_load = 0;
    @(posedge clock); #1;
    chk("w16.hold.err", a_err, 1'b0);
    a_load = 1; a_enable = 1; a_seed = 16'hACE1;
    @(posedge clock); #1;
    chk("w16.load.state", a_state, 16'hACE1);
    chk("w16.load.valid", a_valid, 1'b0);
    chk("w16.load.err", a_err, 1'b0);
    chk("w16.load.noise", a_noise, 1'b1);
    a_load = 0;
    @(posedge clock); #1;
    chk("w16.ace1step.state", a_state, 16'h59C3);
    chk("w16.ace1step.valid", a_valid, 1'b1);
    chk("w16.ace1step.noise", a_noise, 1'b0);
    chk("w16.ace1step.pulse", a_pulse, 1'b0);
    a_enable = 0;

    // 4-bit non-maximal taps: period 5, repeating
    @(posedge clock); #1;
    chk("w4.rst.state", c_state, 4'h1);
    c_reset = 0; c_enable = 1;
    for (int i = 0; i < 15; i++) begin
      @(posedge clock); #1;
      chk($sformatf("w4[%0d].state", i), c_state, cexp[i % 5]);
      chk($sformatf("w4[%0d].pulse", i), c_pulse, (i % 5) == 4);
      chk($sformatf("w4[%0d].len", i), c_len, (i >= 4) ? 4'd5 : 4'd0);
    end
    c_enable = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
